// File: rtl/ysyx_220053_mdu.sv
// rtl/ysyx_220053_mdu.sv - iterative RV64M multiply/divide unit
// Radix-2 shift-add multiply and restoring divide on magnitudes, one op in flight.
module ysyx_220053_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [XLEN-1:0]   acc_q, acc_d;     // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;       // multiplier bits / dividend-quotient shifter
  logic [XLEN-1:0]   a_q, a_d;         // multiplicand / divisor magnitude
  logic [2:0]        func3_q, func3_d;
  logic              word_q, word_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;

  logic              is_div, s1_signed, s2_signed, neg1, neg2;
  logic              div0, ovf, illegal;
  logic [XLEN-1:0]   ext1, ext2, mag1, mag2, fast_val, fast_res;
  logic [XLEN:0]     mul_sum, div_rs, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   step_acc, step_lo, quo, rem, field;
  logic [2*XLEN-1:0] prod, prod_f;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

  always_comb begin
    is_div    = func3[2];
    s1_signed = is_div ? !func3[0] : (func3 != 3'b011);
    s2_signed = is_div ? !func3[0] : !func3[1];
    ext1 = word ? (s1_signed ? {{(XLEN-32){src1[31]}}, src1[31:0]} : {{(XLEN-32){1'b0}}, src1[31:0]}) : src1;
    ext2 = word ? (s2_signed ? {{(XLEN-32){src2[31]}}, src2[31:0]} : {{(XLEN-32){1'b0}}, src2[31:0]}) : src2;
    neg1 = s1_signed & ext1[XLEN-1];
    neg2 = s2_signed & ext2[XLEN-1];
    mag1 = neg1 ? -ext1 : ext1;
    mag2 = neg2 ? -ext2 : ext2;
    div0 = is_div & (word ? (src2[31:0] == 32'd0) : (src2 == '0));
    ovf  = is_div & !func3[0] & (&ext2) &
           (ext1 == (word ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}}));
    illegal = word & !is_div & (func3[1:0] != 2'b00);
    fast_val = '0;
    if (div0)     fast_val = func3[1] ? ext1 : '1;
    else if (ovf) fast_val = func3[1] ? '0 : ext1;
    fast_res = word ? {{(XLEN-32){fast_val[31]}}, fast_val[31:0]} : fast_val;
  end

  // One iteration of each algorithm; only the one matching func3_q is committed.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    div_rs   = {acc_q, lo_q[XLEN-1]};
    div_diff = div_rs - {1'b0, a_q};
    div_ge   = (div_rs >= {1'b0, a_q});
    if (func3_q[2]) begin
      step_acc = div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
      step_lo  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_acc = mul_sum[XLEN:1];
      step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = word_q ? {{XLEN{1'b0}}, step_acc[31:0], step_lo[XLEN-1:32]} : {step_acc, step_lo};
    prod_f = neg_res_q ? -prod : prod;
    quo    = neg_res_q ? -step_lo : step_lo;
    rem    = neg_rem_q ? -step_acc : step_acc;
    case (func3_q)
      3'b000:               field = prod_f[XLEN-1:0];
      3'b001, 3'b010, 3'b011: field = prod_f[2*XLEN-1:XLEN];
      3'b100, 3'b101:       field = quo;
      default:              field = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    a_d       = a_q;
    func3_d   = func3_q;
    word_d    = word_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          func3_d   = func3;
          word_d    = word;
          neg_res_d = neg1 ^ neg2;
          neg_rem_d = neg1;
          if (div0 | ovf | illegal) begin
            state_d  = DONE;
            result_d = fast_res;
          end else begin
            state_d = RUN;
            cnt_d   = word ? 6'd31 : 6'd63;
            acc_d   = '0;
            a_d     = is_div ? mag2 : mag1;
            // Word dividends sit in the top half so the MSB-first shift sees them first.
            lo_d    = is_div ? (word ? {mag1[31:0], 32'd0} : mag1) : mag2;
          end
        end
        RUN: begin
          acc_d = step_acc;
          lo_d  = step_lo;
          if (cnt_q == 6'd0) begin
            state_d  = DONE;
            result_d = word_q ? {{(XLEN-32){field[31]}}, field[31:0]} : field;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      func3_q   <= '0;
      word_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      a_q       <= a_d;
      func3_q   <= func3_d;
      word_q    <= word_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end
endmodule

// File: tb/tb_ysyx_220053_mdu.sv
// tb/tb_ysyx_220053_mdu.sv - directed self-checking bench for ysyx_220053_mdu
// Linear directed sequence; expected values are hand-computed constants.
module tb_ysyx_220053_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  func3 = 3'd0;
  logic        word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ysyx_220053_mdu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .func3(func3), .word(word), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input int exp_lat, input logic [63:0] exp_res);
    int lat;
    func3 = f; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result, exp_res);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " in_ready after transfer"}, 64'(in_ready), 64'd1);
    chk({tag, " out_valid after transfer"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    int bad;
    int seen;

    repeat (3) tick();
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result", result, 64'd0);
    rst = 1'b0;
    tick();

    do_op("mul 7*-3", 3'b000, 1'b0, 64'd7, -64'sd3, 65, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul busy in DONE", 64'(busy), 64'd1);
    chk("mul in_ready in DONE", 64'(in_ready), 64'd0);
    drain("mul");

    do_op("mulhu max", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'hFFFF_FFFF_FFFF_FFFE);
    drain("mulhu");
    do_op("mulh -1*-1", 3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'd0);
    drain("mulh");
    do_op("mulhsu -1*2", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
    drain("mulhsu");

    do_op("divw -7/2", 3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    drain("divw");
    do_op("remw -7%2", 3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 33, 64'hFFFF_FFFF_FFFF_FFFF);
    drain("remw");
    do_op("divu 100/7", 3'b101, 1'b0, 64'd100, 64'd7, 65, 64'd14);
    drain("divu");
    do_op("remu 100%7", 3'b111, 1'b0, 64'd100, 64'd7, 65, 64'd2);
    drain("remu");
    do_op("mulw 0x8000_0001*3", 3'b000, 1'b1, 64'h0000_0000_8000_0001, 64'd3, 33, 64'hFFFF_FFFF_8000_0003);
    drain("mulw");

    do_op("div 5/0", 3'b100, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    drain("div0");
    do_op("rem 5/0", 3'b110, 1'b0, 64'd5, 64'd0, 1, 64'd5);
    drain("rem0");
    do_op("div overflow", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000);
    drain("ovf");
    do_op("word mulh illegal", 3'b001, 1'b1, 64'd9, 64'd9, 1, 64'd0);
    drain("illegal");

    // flush in RUN cycle 10
    func3 = 3'b000; word = 1'b0; src1 = 64'd3; src2 = 64'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (80) begin
      if (out_valid) seen++;
      tick();
    end
    chk("flush no out_valid", 64'(seen), 64'd0);
    chk("flush keeps result", result, 64'd0);

    // in_valid together with flush in IDLE must not be accepted
    func3 = 3'b100; src1 = 64'd5; src2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush+accept busy", 64'(busy), 64'd0);
    chk("flush+accept out_valid", 64'(out_valid), 64'd0);

    // async reset mid-RUN, with a nonzero result held from the previous op
    do_op("pre-reset div", 3'b100, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    drain("pre-reset");
    func3 = 3'b000; src1 = 64'd7; src2 = 64'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mid-run rst in_ready", 64'(in_ready), 64'd1);
    chk("mid-run rst out_valid", 64'(out_valid), 64'd0);
    chk("mid-run rst busy", 64'(busy), 64'd0);
    chk("mid-run rst result", result, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    do_op("post-reset mul 7*9", 3'b000, 1'b0, 64'd7, 64'd9, 65, 64'd63);
    drain("post-reset");

    // backpressure: hold out_ready low 20 cycles with a competing request
    do_op("bp divu 100/7", 3'b101, 1'b0, 64'd100, 64'd7, 65, 64'd14);
    held = result;
    func3 = 3'b000; src1 = 64'd11; src2 = 64'd13; in_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    chk("bp stable cycles", 64'(bad), 64'd0);
    chk("bp result held", result, 64'd14);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp out_valid after release", 64'(out_valid), 64'd0);
    chk("bp in_ready after release", 64'(in_ready), 64'd1);
    tick();
    chk("bp single transfer busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
